// File: rtl/cluster_pkg.sv
// Shared definitions for the cluster link receive path.
// Contents: pad/cluster sizing, field widths, the null address code, err_flags bit indices
// and the unpacker FSM state type.
package cluster_pkg;

  localparam int unsigned MXPADS     = 768;
  localparam int unsigned MXCLUSTERS = 8;
  localparam int unsigned ADR_W      = 11;
  localparam int unsigned CNT_W      = 3;
  localparam int unsigned NCL_W      = 4;

  // Encoder emits this address when it has no cluster to report.
  localparam logic [ADR_W-1:0] ADR_NULL = 11'h7FF;

  // err_flags = {frame_overrun, cluster_overflow, dup_pad, bad_adr}
  localparam int unsigned ERR_BAD_ADR          = 0;
  localparam int unsigned ERR_DUP_PAD          = 1;
  localparam int unsigned ERR_CLUSTER_OVERFLOW = 2;
  localparam int unsigned ERR_FRAME_OVERRUN    = 3;

  typedef enum logic {
    ACCUM,
    HOLD
  } state_e;

endpackage

// File: rtl/cluster_pad_decode.sv
// Decodes one encoded cluster into pad-space masks.
// Ports:
//   adr        in   leading pad address of the cluster
//   cnt        in   cluster size minus 1 (only present with STRIP_MAP_EN)
//   adr_ok     out  address names a real pad (0..MXPADS-1)
//   pad_sel    out  one-hot select of the leading pad, all-zero when adr_ok=0
//   strip_mask out  pads adr..min(adr+cnt, MXPADS-1) (only present with STRIP_MAP_EN)
// Configuration macro: STRIP_MAP_EN adds the cnt input and strip_mask output.
module cluster_pad_decode
  import cluster_pkg::*;
(
  input  logic [ADR_W-1:0]  adr,
`ifdef STRIP_MAP_EN
  input  logic [CNT_W-1:0]  cnt,
  output logic [MXPADS-1:0] strip_mask,
`endif
  output logic              adr_ok,
  output logic [MXPADS-1:0] pad_sel
);

  // The null code is already out of range; it is named here so the intent is visible.
  assign adr_ok = (adr != ADR_NULL) && (adr < ADR_W'(MXPADS));

  always_comb begin
    pad_sel = '0;
    for (int i = 0; i < int'(MXPADS); i++) begin
      pad_sel[i] = adr_ok && (adr == ADR_W'(i));
    end
  end

`ifdef STRIP_MAP_EN
  // One extra bit of headroom so adr+cnt never wraps; pads above MXPADS-1 simply do not exist,
  // which gives the top-edge clip for free.
  logic [ADR_W:0] strip_lo;
  logic [ADR_W:0] strip_hi;

  assign strip_lo = {1'b0, adr};
  assign strip_hi = strip_lo + {{(ADR_W + 1 - CNT_W){1'b0}}, cnt};

  always_comb begin
    strip_mask = '0;
    for (int i = 0; i < int'(MXPADS); i++) begin
      strip_mask[i] = adr_ok && ((ADR_W + 1)'(i) >= strip_lo) && ((ADR_W + 1)'(i) <= strip_hi);
    end
  end
`endif

endmodule

// File: rtl/cluster_unpacker768.sv
// Rebuilds the per-pad vpf/cnt frame from a stream of encoded clusters (one per clock).
// Ports:
//   clock, global_reset_n   clock and asynchronous active-low reset
//   clst_valid/adr/cnt      incoming cluster (cnt = size-1)
//   frame_end               last cycle of a frame; may carry a cluster too
//   out_ready               downstream accepts the held frame
//   out_valid               vpfs_out/cnts_out/nclusters_out hold a complete frame
//   vpfs_out                leading-pad flags
//   cnts_out                per-pad cnt, pad i at [3i+2:3i], zero where vpf=0
//   nclusters_out           clusters accepted into the output frame
//   err_flags               sticky {frame_overrun, cluster_overflow, dup_pad, bad_adr}
//   strips_out              pads covered by accepted clusters (only with STRIP_MAP_EN)
// Configuration macro: STRIP_MAP_EN enables the strip map output.
module cluster_unpacker768
  import cluster_pkg::*;
(
  input  logic                    clock,
  input  logic                    global_reset_n,
  input  logic                    clst_valid,
  input  logic [ADR_W-1:0]        clst_adr,
  input  logic [CNT_W-1:0]        clst_cnt,
  input  logic                    frame_end,
  input  logic                    out_ready,
  output logic                    out_valid,
  output logic [MXPADS-1:0]       vpfs_out,
  output logic [MXPADS*CNT_W-1:0] cnts_out,
  output logic [NCL_W-1:0]        nclusters_out,
`ifdef STRIP_MAP_EN
  output logic [MXPADS-1:0]       strips_out,
`endif
  output logic [3:0]              err_flags
);

  // Reset asserts immediately but is released only on a clock edge, so no flop sees a
  // deassertion close to its active edge.
  logic [1:0] rst_sync;
  logic       rst_n;

  always_ff @(posedge clock or negedge global_reset_n) begin
    if (!global_reset_n) begin
      rst_sync <= '0;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end

  assign rst_n = rst_sync[1];

  logic              adr_ok;
  logic [MXPADS-1:0] pad_sel;
`ifdef STRIP_MAP_EN
  logic [MXPADS-1:0] strip_mask;
`endif

  cluster_pad_decode u_decode (
    .adr        (clst_adr),
`ifdef STRIP_MAP_EN
    .cnt        (clst_cnt),
    .strip_mask (strip_mask),
`endif
    .adr_ok     (adr_ok),
    .pad_sel    (pad_sel)
  );

  // Accumulator for the frame currently being received.
  logic [MXPADS-1:0]       acc_vpf;
  logic [MXPADS*CNT_W-1:0] acc_cnt;
  logic [NCL_W-1:0]        acc_n;
`ifdef STRIP_MAP_EN
  logic [MXPADS-1:0]       acc_strip;
`endif

  state_e state;

  logic acc_full;
  logic take;
  logic bad_adr;
  logic overflow;
  logic dup_pad;
  logic overrun;
  logic load;

  assign acc_full = (acc_n == NCL_W'(MXCLUSTERS));
  assign take     = clst_valid && adr_ok && !acc_full;
  assign bad_adr  = clst_valid && !adr_ok;
  assign overflow = clst_valid && adr_ok && acc_full;
  assign dup_pad  = take && |(acc_vpf & pad_sel);
  assign overrun  = frame_end && (state == HOLD) && !out_ready;
  // A frame is published when the output side is free or being drained this very cycle.
  assign load     = frame_end && ((state == ACCUM) || out_ready);

  // Accumulator merged with this cycle's cluster; this is what a frame_end publishes.
  logic [MXPADS-1:0]       mrg_vpf;
  logic [MXPADS*CNT_W-1:0] mrg_cnt;
  logic [NCL_W-1:0]        mrg_n;
`ifdef STRIP_MAP_EN
  logic [MXPADS-1:0]       mrg_strip;

  assign mrg_strip = take ? (acc_strip | strip_mask) : acc_strip;
`endif

  assign mrg_vpf = take ? (acc_vpf | pad_sel) : acc_vpf;
  assign mrg_n   = acc_n + NCL_W'(take);

  always_comb begin
    mrg_cnt = acc_cnt;
    for (int i = 0; i < int'(MXPADS); i++) begin
      // Later cluster on the same pad overwrites the earlier cnt.
      if (take && pad_sel[i]) begin
        mrg_cnt[i*CNT_W +: CNT_W] = clst_cnt;
      end
    end
  end

  // Accumulation never stalls; a frame_end always empties it, published or discarded.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      acc_vpf   <= '0;
      acc_cnt   <= '0;
      acc_n     <= '0;
`ifdef STRIP_MAP_EN
      acc_strip <= '0;
`endif
    end else if (frame_end) begin
      acc_vpf   <= '0;
      acc_cnt   <= '0;
      acc_n     <= '0;
`ifdef STRIP_MAP_EN
      acc_strip <= '0;
`endif
    end else begin
      acc_vpf   <= mrg_vpf;
      acc_cnt   <= mrg_cnt;
      acc_n     <= mrg_n;
`ifdef STRIP_MAP_EN
      acc_strip <= mrg_strip;
`endif
    end
  end

  // Output FSM with registered frame outputs and sticky error flags.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ACCUM;
      out_valid     <= 1'b0;
      vpfs_out      <= '0;
      cnts_out      <= '0;
      nclusters_out <= '0;
`ifdef STRIP_MAP_EN
      strips_out    <= '0;
`endif
      err_flags     <= '0;
    end else begin
      err_flags[ERR_BAD_ADR]          <= err_flags[ERR_BAD_ADR] | bad_adr;
      err_flags[ERR_DUP_PAD]          <= err_flags[ERR_DUP_PAD] | dup_pad;
      err_flags[ERR_CLUSTER_OVERFLOW] <= err_flags[ERR_CLUSTER_OVERFLOW] | overflow;
      err_flags[ERR_FRAME_OVERRUN]    <= err_flags[ERR_FRAME_OVERRUN] | overrun;

      if (load) begin
        vpfs_out      <= mrg_vpf;
        cnts_out      <= mrg_cnt;
        nclusters_out <= mrg_n;
`ifdef STRIP_MAP_EN
        strips_out    <= mrg_strip;
`endif
        out_valid     <= 1'b1;
        state         <= HOLD;
      end else if ((state == HOLD) && out_ready) begin
        out_valid     <= 1'b0;
        state         <= ACCUM;
      end
    end
  end

endmodule
